// File: rtl/axi_stream_packet_arbiter_pkg.sv
// Shared types and the round-robin selection function for the packet arbiter.
// rr_pick scans a zero-extended request vector starting just after ptr.
package axi_stream_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

   localparam int RR_MAX_IN = 32;
   localparam int RR_IDX_W  = 5;

   // Scan from the farthest candidate to the nearest so that the closest
   // request after ptr is the last one written and therefore wins.
   function automatic int rr_pick(input logic [RR_MAX_IN-1:0] req,
                                  input int ptr,
                                  input int num_in);
      int idx;
      rr_pick = 0;
      for (int k = RR_MAX_IN; k >= 1; k--) begin
         if (k <= num_in) begin
            idx = (ptr + k) % num_in;
            if (req[idx[RR_IDX_W-1:0]]) begin
               rr_pick = idx;
            end
         end
      end
   endfunction

endpackage

// File: rtl/axi_stream_packet_arbiter_rr_picker.sv
// Combinational round-robin priority select: first request after ptr, wrapping.
// gnt_any qualifies gnt_idx; gnt_idx is 0 when nothing is requested.
module rr_picker
   import axi_stream_arb_pkg::*;
#(
   parameter int NUM_IN   = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_IN-1:0]   req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [ID_WIDTH-1:0] gnt_idx,
   output logic                gnt_any
);

   logic [RR_MAX_IN-1:0] req_ext;

   always_comb begin
      req_ext = RR_MAX_IN'(req);
      gnt_idx = ID_WIDTH'(rr_pick(req_ext, int'(ptr), NUM_IN));
      gnt_any = |req;
   end

endmodule

// File: rtl/axi_stream_packet_arbiter.sv
// Round-robin, packet-locked AXI-stream arbiter with one registered output stage.
// The granted input owns the output until its last beat; out_id tags each beat's source.
module axi_stream_packet_arbiter
   import axi_stream_arb_pkg::*;
#(
   parameter int NUM_IN      = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int PARALLELISM = 4,
   parameter int ID_WIDTH    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_IN*DATA_WIDTH-1:0]  in_data,
   input  logic [NUM_IN-1:0]             in_last,
   input  logic [NUM_IN*PARALLELISM-1:0] in_mask,
   input  logic [NUM_IN-1:0]             in_valid,
   output logic [NUM_IN-1:0]             in_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_last,
   output logic [PARALLELISM-1:0]        out_mask,
   output logic [ID_WIDTH-1:0]           out_id,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy
);

   arb_state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]       grant_q, grant_d;
   logic [ID_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
   logic                      out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
   logic                      out_last_q, out_last_d;
   logic [PARALLELISM-1:0]    out_mask_q, out_mask_d;
   logic [ID_WIDTH-1:0]       out_id_q, out_id_d;

   logic [ID_WIDTH-1:0]       pick_idx;
   logic                      pick_any;
   logic                      can_load;
   logic                      accept;
   logic                      sel_valid;
   logic                      sel_last;
   logic [DATA_WIDTH-1:0]     sel_data;
   logic [PARALLELISM-1:0]    sel_mask;

   rr_picker #(
      .NUM_IN   (NUM_IN),
      .ID_WIDTH (ID_WIDTH)
   ) u_picker (
      .req     (in_valid),
      .ptr     (rr_ptr_q),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   // The output slot can take a beat when empty or being drained this cycle.
   assign can_load = !out_valid_q || out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_ready
         assign in_ready[gi] = (state_q == ARB_LOCKED) && (grant_q == ID_WIDTH'(gi)) && can_load;
      end
   endgenerate

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_mask  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_q == ID_WIDTH'(i)) begin
            sel_valid = in_valid[i];
            sel_last  = in_last[i];
            sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_mask  = in_mask[i*PARALLELISM +: PARALLELISM];
         end
      end
      accept = (state_q == ARB_LOCKED) && can_load && sel_valid;
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_mask_d  = out_mask_q;
      out_id_d    = out_id_q;

      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               state_d = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            if (accept && sel_last) begin
               state_d  = ARB_IDLE;
               rr_ptr_d = grant_q;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_last_d  = sel_last;
         out_mask_d  = sel_mask;
         out_id_d    = grant_q;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= ID_WIDTH'(NUM_IN - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_mask_q  <= '0;
         out_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_mask_q  <= out_mask_d;
         out_id_q    <= out_id_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_mask  = out_mask_q;
   assign out_id    = out_id_q;
   assign busy      = (state_q == ARB_LOCKED);

endmodule
